// File: rtl/serial_receiver_if.sv
// Serial receiver bus: the async RX line plus the received byte and its ready status.
// The receiver uses the slave modport; whatever drives the line and consumes bytes
// uses master.
interface serial_receiver_if;
    logic       IN_SERIAL_RX;
    logic [7:0] data;
    logic       ready;

    modport master (
        output IN_SERIAL_RX,
        input  data,
        input  ready
    );

    modport slave (
        input  IN_SERIAL_RX,
        output data,
        output ready
    );
endinterface

// File: rtl/serial_receiver.sv
// UART-style 8N1 receiver (LSB first, idle-high line).
// Each bit is sampled at its centre, timed from the synchronized start edge.
// ready is low while a frame is in progress. It rises on the same edge that a
// correctly framed byte is written to data.
module serial_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              CLK,
    input  logic              RESET,
    serial_receiver_if.slave  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic             rx_meta_q;
    logic             rx_s_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             ready_q;

    // Two-flop synchronizer. Both flops reset to the idle (high) line level.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.IN_SERIAL_RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM. Counters, the shift register and the registered outputs all
    // update here.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (!rx_s_q) begin
                            state_q <= S_DATA;
                        end else begin
                            // The line went high again before mid start bit,
                            // so this was a glitch and not a frame.
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            bit_q   <= '0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            // A low stop bit is a framing error. Drop the byte and
                            // wait for the line to return to idle.
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data  = data_q;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_serial_receiver.sv
// Directed plus randomized bench for serial_receiver at 16 clocks per bit.
// The reference model tracks only the last good byte and how many times ready
// should have risen.
module tb_serial_receiver;
    localparam int CPB = 16;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    serial_receiver_if bus_if ();

    serial_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if)
    );

    always #5 CLK = ~CLK;

    int         n_cmp     = 0;
    int         n_fail    = 0;
    int         rises     = 0;
    int         exp_rises = 0;
    logic [7:0] exp_data  = 8'h00;
    logic       ready_prev = 1'b1;

    // Count 0->1 transitions of ready, sampled on the falling clock edge.
    always @(negedge CLK) begin
        if (ready_prev === 1'b0 && bus_if.ready === 1'b1) rises <= rises + 1;
        ready_prev <= bus_if.ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus_if.IN_SERIAL_RX = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        bus_if.IN_SERIAL_RX = b;
        repeat (CPB) @(negedge CLK);
    endtask

    // One full frame. Checks that ready drops within 3 clocks of the start edge
    // and is still low at the end of the last data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input string tag);
        bus_if.IN_SERIAL_RX = 1'b0;
        repeat (3) @(negedge CLK);
        check({tag, " ready_fall"}, 32'(bus_if.ready), 32'h0);
        repeat (CPB - 3) @(negedge CLK);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        check({tag, " ready_busy"}, 32'(bus_if.ready), 32'h0);
        send_bit(stop_bit);
    endtask

    initial begin
        logic [7:0] b;
        logic       good;
        logic       stayed;
        int         gap;

        bus_if.IN_SERIAL_RX = 1'b1;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        check("reset data", 32'(bus_if.data), 32'(exp_data));
        check("reset ready", 32'(bus_if.ready), 32'h1);
        stayed = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus_if.ready !== 1'b1) stayed = 1'b0;
        end
        check("idle ready stays", 32'(stayed), 32'h1);
        $display("reset: data=%h ready=%b", bus_if.data, bus_if.ready);

        // Single frame.
        send_frame(8'h55, 1'b1, "f55");
        exp_data = 8'h55; exp_rises++;
        check("f55 data", 32'(bus_if.data), 32'(exp_data));
        check("f55 ready", 32'(bus_if.ready), 32'h1);
        check("f55 rises", 32'(rises), 32'(exp_rises));
        $display("frame 55: data=%h rises=%0d", bus_if.data, rises);

        // Two frames back to back, with no idle gap between them.
        idle(CPB);
        send_frame(8'hA3, 1'b1, "fA3");
        exp_data = 8'hA3; exp_rises++;
        check("fA3 data", 32'(bus_if.data), 32'(exp_data));
        send_frame(8'h0F, 1'b1, "f0F");
        exp_data = 8'h0F; exp_rises++;
        check("f0F data", 32'(bus_if.data), 32'(exp_data));
        check("b2b rises", 32'(rises), 32'(exp_rises));
        $display("back-to-back A3,0F: data=%h rises=%0d", bus_if.data, rises);

        // Start glitch: the line is low for only 4 clocks.
        idle(CPB);
        bus_if.IN_SERIAL_RX = 1'b0;
        repeat (4) @(negedge CLK);
        check("glitch drop", 32'(bus_if.ready), 32'h0);
        bus_if.IN_SERIAL_RX = 1'b1;
        repeat (20) @(negedge CLK);
        exp_rises++;
        check("glitch ready", 32'(bus_if.ready), 32'h1);
        check("glitch data", 32'(bus_if.data), 32'(exp_data));
        check("glitch rises", 32'(rises), 32'(exp_rises));
        $display("glitch: data=%h ready=%b", bus_if.data, bus_if.ready);

        // Framing error: the stop bit is low, then the line is held low for 40 more clocks.
        send_frame(8'h81, 1'b0, "ferr");
        repeat (40) @(negedge CLK);
        check("ferr ready low", 32'(bus_if.ready), 32'h0);
        check("ferr data held", 32'(bus_if.data), 32'(exp_data));
        bus_if.IN_SERIAL_RX = 1'b1;
        repeat (5) @(negedge CLK);
        exp_rises++;
        check("ferr ready back", 32'(bus_if.ready), 32'h1);
        check("ferr data after", 32'(bus_if.data), 32'(exp_data));
        check("ferr rises", 32'(rises), 32'(exp_rises));
        $display("framing error 81: data=%h ready=%b", bus_if.data, bus_if.ready);

        // Randomized frames: random idle gaps (0 means back to back) and occasional bad stop bits.
        for (int k = 0; k < 10; k++) begin
            b    = 8'($urandom);
            gap  = $urandom_range(0, 2 * CPB);
            good = ($urandom_range(0, 3) != 0);
            idle(gap);
            send_frame(b, good, "rand");
            if (good) exp_data = b;
            else      idle(8);
            exp_rises++;
            check("rand data", 32'(bus_if.data), 32'(exp_data));
            check("rand rises", 32'(rises), 32'(exp_rises));
            $display("rand frame %0d: byte=%h stop=%b data=%h", k, b, good, bus_if.data);
        end

        // Reset during a frame, after data bit 3.
        idle(CPB);
        b = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        RESET = 1'b1;
        bus_if.IN_SERIAL_RX = 1'b1;
        @(negedge CLK);
        exp_data = 8'h00; exp_rises++;
        check("midrst ready", 32'(bus_if.ready), 32'h1);
        check("midrst data", 32'(bus_if.data), 32'(exp_data));
        @(negedge CLK);
        RESET = 1'b0;
        idle(CPB);
        send_frame(8'hC4, 1'b1, "fC4");
        exp_data = 8'hC4; exp_rises++;
        check("fC4 data", 32'(bus_if.data), 32'(exp_data));
        check("fC4 rises", 32'(rises), 32'(exp_rises));
        $display("after mid-frame reset C4: data=%h", bus_if.data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
